// File: rtl/display_timings_multi.sv
// Multi-mode video timing generator: 640x480, 800x600 and 1280x720 with frame-boundary mode switching.
// Define DISPLAY_FRAME_CNT_EN to add the 32-bit frame_cnt output.
module display_timings_multi #(
  parameter int         CORDW    = 16,
  parameter logic [1:0] MODE_RST = 2'd0
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic [1:0]              mode_req,
  input  logic signed [CORDW-1:0] cmp_line,
  output logic [1:0]              mode_cur,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic                    mode_chg,
  output logic                    line_match,
`ifdef DISPLAY_FRAME_CNT_EN
  output logic [31:0]             frame_cnt,
`endif
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy
);

  typedef logic signed [CORDW-1:0] coord_t;
  typedef struct packed {
    coord_t res;
    coord_t fp;
    coord_t sync;
    coord_t bp;
    logic   pos;
  } axis_t;

  localparam coord_t     ONE          = coord_t'(1);
  localparam coord_t     ZERO         = '0;
  localparam logic [1:0] MODE_RST_MAP = (MODE_RST == 2'd3) ? 2'd0 : MODE_RST;

  // Mode 3 and any unlisted code fall back to the 640x480 timing.
  function automatic axis_t axis_of(input logic [1:0] m, input logic vert);
    axis_t a;
    case (m)
      2'd1: a = vert ? '{coord_t'(600), coord_t'(1), coord_t'(4), coord_t'(23), 1'b1}
                     : '{coord_t'(800), coord_t'(40), coord_t'(128), coord_t'(88), 1'b1};
      2'd2: a = vert ? '{coord_t'(720), coord_t'(5), coord_t'(5), coord_t'(20), 1'b1}
                     : '{coord_t'(1280), coord_t'(110), coord_t'(40), coord_t'(220), 1'b1};
      default: a = vert ? '{coord_t'(480), coord_t'(10), coord_t'(2), coord_t'(33), 1'b0}
                        : '{coord_t'(640), coord_t'(16), coord_t'(96), coord_t'(48), 1'b0};
    endcase
    return a;
  endfunction

  function automatic coord_t sta_of(input axis_t a);
    return -(a.fp + a.sync + a.bp);
  endfunction

  logic [1:0] mode_q, mode_d, mode_n;
  coord_t     x_q, x_d, y_q, y_d;
  axis_t      h_c, v_c;
  coord_t     h_sta, v_sta, hs_sta, vs_sta, nxt_h_sta, nxt_v_sta, rst_h_sta, rst_v_sta;
  logic       rst_h_pos, rst_v_pos, hs_act, vs_act, x_last, y_last, frame_c, line_c;

  logic [1:0] mode_cur_q;
  logic       hsync_q, vsync_q, de_q, frame_q, line_q, mode_chg_q, line_match_q;
  coord_t     sx_q, sy_q;

  assign mode_n    = (mode_req == 2'd3) ? 2'd0 : mode_req;
  assign h_c       = axis_of(mode_q, 1'b0);
  assign v_c       = axis_of(mode_q, 1'b1);
  assign h_sta     = sta_of(h_c);
  assign v_sta     = sta_of(v_c);
  assign hs_sta    = h_sta + h_c.fp;
  assign vs_sta    = v_sta + v_c.fp;
  assign nxt_h_sta = sta_of(axis_of(mode_n, 1'b0));
  assign nxt_v_sta = sta_of(axis_of(mode_n, 1'b1));
  assign rst_h_sta = sta_of(axis_of(MODE_RST_MAP, 1'b0));
  assign rst_v_sta = sta_of(axis_of(MODE_RST_MAP, 1'b1));
  assign rst_h_pos = axis_of(MODE_RST_MAP, 1'b0).pos;
  assign rst_v_pos = axis_of(MODE_RST_MAP, 1'b1).pos;

  assign hs_act  = (x_q >= hs_sta) && (x_q < hs_sta + h_c.sync);
  assign vs_act  = (y_q >= vs_sta) && (y_q < vs_sta + v_c.sync);
  assign x_last  = (x_q == h_c.res - ONE);
  assign y_last  = (y_q == v_c.res - ONE);
  assign frame_c = (x_q == h_sta) && (y_q == v_sta);
  assign line_c  = (x_q == h_sta);

  // mode_req is only looked at on the last pixel, so a frame never mixes timings.
  always_comb begin
    x_d    = x_q + ONE;
    y_d    = y_q;
    mode_d = mode_q;
    if (x_last) begin
      x_d = h_sta;
      if (y_last) begin
        mode_d = mode_n;
        x_d    = nxt_h_sta;
        y_d    = nxt_v_sta;
      end else begin
        y_d = y_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      mode_q       <= MODE_RST_MAP;
      x_q          <= rst_h_sta;
      y_q          <= rst_v_sta;
      mode_cur_q   <= MODE_RST_MAP;
      sx_q         <= rst_h_sta;
      sy_q         <= rst_v_sta;
      hsync_q      <= ~rst_h_pos;
      vsync_q      <= ~rst_v_pos;
      de_q         <= 1'b0;
      frame_q      <= 1'b0;
      line_q       <= 1'b0;
      mode_chg_q   <= 1'b0;
      line_match_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mode_cur_q   <= mode_q;
      sx_q         <= x_q;
      sy_q         <= y_q;
      hsync_q      <= h_c.pos ? hs_act : ~hs_act;
      vsync_q      <= v_c.pos ? vs_act : ~vs_act;
      de_q         <= (x_q >= ZERO) && (y_q >= ZERO);
      frame_q      <= frame_c;
      line_q       <= line_c;
      // mode_cur_q still holds the previous frame's mode on this edge.
      mode_chg_q   <= frame_c && (mode_q != mode_cur_q);
      line_match_q <= line_c && (y_q == cmp_line);
    end
  end

`ifdef DISPLAY_FRAME_CNT_EN
  logic [31:0] frame_cnt_q;
  always_ff @(posedge clk_pix) begin
    if (rst_pix)      frame_cnt_q <= '0;
    else if (frame_c) frame_cnt_q <= frame_cnt_q + 32'd1;
  end
  assign frame_cnt = frame_cnt_q;
`endif

  assign mode_cur   = mode_cur_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;
  assign frame      = frame_q;
  assign line       = line_q;
  assign mode_chg   = mode_chg_q;
  assign line_match = line_match_q;
  assign sx         = sx_q;
  assign sy         = sy_q;

endmodule

// File: tb/tb_display_timings_multi.sv
// Bench for display_timings_multi: four instances (MODE_RST 0..3) checked every cycle against a frame-position model.
module tb_display_timings_multi;
  localparam int N = 4;

  localparam int H_RES [3] = '{640, 800, 1280};
  localparam int H_FP  [3] = '{16, 40, 110};
  localparam int H_SY  [3] = '{96, 128, 40};
  localparam int H_BP  [3] = '{48, 88, 220};
  localparam int V_RES [3] = '{480, 600, 720};
  localparam int V_FP  [3] = '{10, 1, 5};
  localparam int V_SY  [3] = '{2, 4, 5};
  localparam int V_BP  [3] = '{33, 23, 20};
  localparam bit POS   [3] = '{1'b0, 1'b1, 1'b1};

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic               rst_pix;
  logic [1:0]         mode_req [N];
  logic signed [15:0] cmp_line [N];
  logic [1:0]         mode_cur [N];
  logic               hsync [N], vsync [N], de [N], frame [N], line [N];
  logic               mode_chg [N], line_match [N];
  logic signed [15:0] sx [N], sy [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    display_timings_multi #(.CORDW(16), .MODE_RST(2'(g))) u_dut (
      .clk_pix   (clk_pix),
      .rst_pix   (rst_pix),
      .mode_req  (mode_req[g]),
      .cmp_line  (cmp_line[g]),
      .mode_cur  (mode_cur[g]),
      .hsync     (hsync[g]),
      .vsync     (vsync[g]),
      .de        (de[g]),
      .frame     (frame[g]),
      .line      (line[g]),
      .mode_chg  (mode_chg[g]),
      .line_match(line_match[g]),
      .sx        (sx[g]),
      .sy        (sy[g])
    );
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: mode of the displayed frame and the pixel index within that frame.
  int m_mode [N], m_prev [N], m_pend [N], m_n [N], last_line [N];
  bit m_run [N];

  function automatic int mapm(input int m);
    return (m == 3) ? 0 : m;
  endfunction

  function automatic int htot(input int m);
    return H_RES[m] + H_FP[m] + H_SY[m] + H_BP[m];
  endfunction

  function automatic int vtot(input int m);
    return V_RES[m] + V_FP[m] + V_SY[m] + V_BP[m];
  endfunction

  task automatic model_update(input int g);
    if (rst_pix) begin
      m_mode[g]    = mapm(g);
      m_prev[g]    = m_mode[g];
      m_pend[g]    = m_mode[g];
      m_n[g]       = 0;
      m_run[g]     = 1'b0;
      last_line[g] = -1;
    end else if (!m_run[g]) begin
      m_run[g] = 1'b1;
      m_n[g]   = 0;
    end else begin
      m_n[g]++;
      if (m_n[g] == htot(m_mode[g]) * vtot(m_mode[g])) begin
        m_n[g]    = 0;
        m_prev[g] = m_mode[g];
        m_mode[g] = m_pend[g];
      end
      if (m_n[g] == htot(m_mode[g]) * vtot(m_mode[g]) - 1)
        m_pend[g] = mapm(int'(mode_req[g]));
    end
  endtask

  task automatic check(input int g);
    int m, ht, hsta, vsta, x, y;
    logic hs, vs, en, fr, ln, chg, lm;
    logic [1:0]  em;
    logic [40:0] exp_v, got_v;
    m    = m_mode[g];
    ht   = htot(m);
    hsta = -(H_FP[m] + H_SY[m] + H_BP[m]);
    vsta = -(V_FP[m] + V_SY[m] + V_BP[m]);
    if (!m_run[g]) begin
      x = hsta; y = vsta;
      hs = !POS[m]; vs = !POS[m];
      en = 0; fr = 0; ln = 0; chg = 0; lm = 0;
    end else begin
      x   = hsta + m_n[g] % ht;
      y   = vsta + m_n[g] / ht;
      hs  = (x >= hsta + H_FP[m] && x < hsta + H_FP[m] + H_SY[m]) ? POS[m] : !POS[m];
      vs  = (y >= vsta + V_FP[m] && y < vsta + V_FP[m] + V_SY[m]) ? POS[m] : !POS[m];
      en  = (x >= 0) && (y >= 0);
      fr  = (m_n[g] == 0);
      ln  = (m_n[g] % ht == 0);
      chg = fr && (m_mode[g] != m_prev[g]);
      lm  = ln && (y == int'(cmp_line[g]));
    end
    em    = 2'(m);
    exp_v = {em, hs, vs, en, fr, ln, chg, lm, x[15:0], y[15:0]};
    got_v = {mode_cur[g], hsync[g], vsync[g], de[g], frame[g], line[g], mode_chg[g],
             line_match[g], sx[g], sy[g]};
    n_assert++;
    assert (got_v === exp_v)
      else begin
        n_fail++;
        $error("FAIL outputs[%0d] cyc=%0d observed=%h expected=%h (mode,hs,vs,de,fr,ln,chg,lm,sx,sy)",
               g, cyc, got_v, exp_v);
      end
    if (m_run[g] && line[g] === 1'b1) begin
      if (last_line[g] >= 0) begin
        n_assert++;
        assert (cyc - last_line[g] == ht)
          else begin
            n_fail++;
            $error("FAIL line_period[%0d] cyc=%0d observed=%0d expected=%0d",
                   g, cyc, cyc - last_line[g], ht);
          end
      end
      last_line[g] = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
    cyc++;
    for (int g = 0; g < N; g++) begin
      model_update(g);
      check(g);
    end
  endtask

  task automatic shuffle_req();
    for (int g = 0; g < N; g++) mode_req[g] = 2'($urandom);
  endtask

  int n_first;
  int t;

  initial begin
    rst_pix = 1'b1;
    for (int g = 0; g < N; g++) begin
      mode_req[g]  = 2'(g);
      m_mode[g]    = mapm(g);
      m_prev[g]    = m_mode[g];
      m_pend[g]    = m_mode[g];
      m_n[g]       = 0;
      m_run[g]     = 1'b0;
      last_line[g] = -1;
    end
    cmp_line[0] = 16'sd0;
    cmp_line[1] = -16'sd30;
    t = -int'($urandom_range(30, 0));
    cmp_line[2] = 16'(t);
    t = -int'($urandom_range(45, 38));
    cmp_line[3] = 16'(t);

    repeat (3) step();
    rst_pix = 1'b0;
    step();
    n_assert++;
    assert (sx[0] === -16'sd160 && sy[0] === -16'sd45 && frame[0] === 1'b1 && mode_chg[0] === 1'b0)
      else begin
        n_fail++;
        $error("FAIL first_out observed sx=%0d sy=%0d frame=%b chg=%b expected sx=-160 sy=-45 frame=1 chg=0",
               sx[0], sy[0], frame[0], mode_chg[0]);
      end

    n_first = int'($urandom_range(6000, 3000));
    for (int i = 0; i < n_first; i++) begin
      shuffle_req();
      step();
    end

    rst_pix = 1'b1;
    shuffle_req();
    step();
    step();
    rst_pix = 1'b0;

    for (int i = 0; i < 51000; i++) begin
      shuffle_req();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_timings_multi.md
DISPLAY_TIMINGS_MULTI -- requirements
Module: display_timings_multi

Interface
REQ-001 SHALL have parameter CORDW, default 16: signed coordinate width in bits, minimum 12.
REQ-002 SHALL have parameter MODE_RST, default 0: timing mode loaded at reset.
REQ-003 SHALL have port clk_pix, input, 1 bit: pixel clock. The single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_pix, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port mode_req, input, 2 bits: requested timing mode.
REQ-006 SHALL have port cmp_line, input, signed CORDW bits: line number to compare against.
REQ-007 SHALL have port mode_cur, output, 2 bits: timing mode in effect for the current frame.
REQ-008 SHALL have ports hsync and vsync, output, 1 bit each: sync signals, polarity per mode.
REQ-009 SHALL have port de, output, 1 bit: high in the active area.
REQ-010 SHALL have ports frame and line, output, 1 bit each: 1-cycle pulses at the first blanking pixel of the frame and of each line.
REQ-011 SHALL have port mode_chg, output, 1 bit: 1-cycle pulse coincident with frame when mode_cur differs from the previous frame's mode.
REQ-012 SHALL have port line_match, output, 1 bit: 1-cycle pulse coincident with line when sy equals cmp_line.
REQ-013 SHALL have ports sx and sy, output, signed CORDW bits each: screen position; active area is 0..RES-1.

Function
REQ-014 SHALL support these modes (res, FP, SYNC, BP, polarity):
- mode 0, H: 640, 16, 96, 48, neg; V: 480, 10, 2, 33, neg.
- mode 1, H: 800, 40, 128, 88, pos; V: 600, 1, 4, 23, pos.
- mode 2, H: 1280, 110, 40, 220, pos; V: 720, 5, 5, 20, pos.
- mode 3 SHALL map to mode 0.
REQ-015 SHALL use these internal counter ranges:
- x runs from H_STA=-(FP+SYNC+BP) to H_RES-1.
- y runs from V_STA to V_RES-1.
- x wraps to H_STA after H_RES-1 and increments y; y wraps to V_STA after V_RES-1.
REQ-016 SHALL assert sync (polarity-corrected) for HS_STA=H_STA+H_FP <= x < HS_STA+H_SYNC; vertical sync is analogous.
REQ-017 SHALL register every output one cycle after the internal x/y; sx/sy equal the delayed x/y, aligned with hsync, vsync, de, frame and line.
REQ-018 SHALL drive de as (y>=0 && x>=0), frame as (x==H_STA && y==V_STA), and line as (x==H_STA).
REQ-019 SHALL sample mode_req only on the cycle x==H_RES-1 && y==V_RES-1, and apply it from the next x==H_STA.
REQ-020 SHALL ignore mode_req changes at any other time; a frame never mixes timings.
REQ-021 SHALL change mode_cur on the same output cycle as the frame pulse of the new mode's first frame.
REQ-022 SHALL use arithmetic of signed CORDW width with no overflow for all modes.

Reset
REQ-023 SHALL, while rst_pix is high, set the mode to MODE_RST (3 maps to 0) and set x=H_STA, y=V_STA.
REQ-024 SHALL hold these outputs during reset: sx=H_STA, sy=V_STA, de=0, frame=0, line=0, mode_chg=0, line_match=0, hsync/vsync at the inactive level of MODE_RST.
REQ-025 SHALL abandon any frame in progress when reset asserts mid-frame; the first cycle after release is x=H_STA, y=V_STA, with the frame pulse one cycle later.

Configuration
REQ-026 SHALL compile in port frame_cnt (output, 32 bits) when DISPLAY_FRAME_CNT_EN is defined.
- frame_cnt resets to 0 and increments by 1 on each frame pulse, wrapping at 2^32-1 -> 0.
- Without the macro, the port and its counter SHALL be absent.

Verification
REQ-027 SHALL cover reset: mode 0, release rst_pix -> sx=-160, sy=-45 on the first output cycle, then frame=1 for one cycle, mode_chg=0.
REQ-028 SHALL cover mode 0 periods: line pulses 800 cycles apart; frame pulses 420000 cycles apart; hsync=0 exactly for sx -144..-49; vsync=0 for sy -35..-34; de=1 for 640x480 pixels per frame.
REQ-029 SHALL cover a mid-frame mode change: mode_req 0->2 at sy=100 -> current frame completes in mode 0; the next frame has mode_cur=2, mode_chg=1 and a line period of 1650, frame period 1650x750, and hsync high for sx -260..-221.
REQ-030 SHALL cover mode 3: request mode 3 -> behaves as mode 0, 800x525 totals.
REQ-031 SHALL cover line compare: cmp_line=0 -> exactly one line_match per frame, coincident with line at sy=0; cmp_line=-30 in mode 1 -> no match.
REQ-032 SHALL cover the frame counter with DISPLAY_FRAME_CNT_EN: after 3 frame pulses, frame_cnt=3; reset mid-frame -> frame_cnt=0.
